cmos_access_arbiter: RTL and testbench

//  Shares the single-port CMOS/RTC register store (addr/dataIn/writeEn, 1-cycle registered dataOut)

---
 rtl/cmos_arb_pkg.sv | 10 +
 rtl/cmos_arb_rr2.sv | 13 +
 rtl/cmos_access_arbiter.sv | 120 ++++++++++++
 tb/tb_cmos_access_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cmos_arb_pkg.sv
// cmos_arb_pkg: shared state encodings, grant ids and defaults for the CMOS access arbiter
package cmos_arb_pkg;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_ACK   = 2'd3;
  localparam logic GNT_I2C  = 1'b0;
  localparam logic GNT_HOST = 1'b1;
  localparam logic [7:0] DIRTY_BASE_DEF = 8'h10;
endpackage

// File: rtl/cmos_arb_rr2.sv
// cmos_arb_rr2: two-way round-robin pick between I2C and host requests
module cmos_arb_rr2
  import cmos_arb_pkg::*;
(
  input  logic i2c_req_i,
  input  logic host_req_i,
  input  logic last_i,
  output logic any_o,
  output logic gnt_o
);
  assign any_o = i2c_req_i | host_req_i;
  assign gnt_o = (i2c_req_i & host_req_i) ? ~last_i : (host_req_i ? GNT_HOST : GNT_I2C);
endmodule

// File: rtl/cmos_access_arbiter.sv
// cmos_access_arbiter: sequences I2C and host accesses to the single-port CMOS store
// through IDLE/ISSUE/WAIT/ACK and tracks whether the CMOS area needs saving.
module cmos_access_arbiter
  import cmos_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter logic [ADDR_W-1:0] DIRTY_BASE = ADDR_W'(DIRTY_BASE_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2c_req_i,
  input  logic              i2c_we_i,
  input  logic [ADDR_W-1:0] i2c_addr_i,
  input  logic [DATA_W-1:0] i2c_wdata_i,
  output logic              i2c_ack_o,
  output logic [DATA_W-1:0] i2c_rdata_o,
  input  logic              host_req_i,
  input  logic              host_we_i,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_ack_o,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              host_dirty_clr_i,
  output logic              dirty_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  logic [1:0] state_q, state_d;
  logic grant_q, grant_d, we_q, we_d, mem_we_q, mem_we_d;
  logic i2c_ack_q, i2c_ack_d, host_ack_q, host_ack_d, dirty_q, dirty_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, i2c_rdata_q, i2c_rdata_d, host_rdata_q, host_rdata_d;
  logic any, pick, set_dirty;

  cmos_arb_rr2 u_rr2 (
    .i2c_req_i  (i2c_req_i),
    .host_req_i (host_req_i),
    .last_i     (grant_q),
    .any_o      (any),
    .gnt_o      (pick)
  );

  // only I2C writes into the CMOS area mark the image dirty; a same-edge clear loses
  assign set_dirty = (state_q == ST_WAIT) & (grant_q == GNT_I2C) & we_q & (mem_addr_q >= DIRTY_BASE);
  assign dirty_d = set_dirty | (dirty_q & ~host_dirty_clr_i);

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    i2c_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    i2c_rdata_d  = i2c_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      ST_IDLE: if (any) begin
        state_d     = ST_ISSUE;
        grant_d     = pick;
        we_d        = pick ? host_we_i : i2c_we_i;
        mem_we_d    = we_d;
        mem_addr_d  = pick ? host_addr_i : i2c_addr_i;
        mem_wdata_d = pick ? host_wdata_i : i2c_wdata_i;
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        state_d      = ST_ACK;
        i2c_ack_d    = grant_q == GNT_I2C;
        host_ack_d   = grant_q == GNT_HOST;
        i2c_rdata_d  = i2c_ack_d ? mem_rdata_i : i2c_rdata_q;
        host_rdata_d = host_ack_d ? mem_rdata_i : host_rdata_q;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_HOST;
      we_q         <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      i2c_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      i2c_rdata_q  <= '0;
      host_rdata_q <= '0;
      dirty_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      we_q         <= we_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      i2c_ack_q    <= i2c_ack_d;
      host_ack_q   <= host_ack_d;
      i2c_rdata_q  <= i2c_rdata_d;
      host_rdata_q <= host_rdata_d;
      dirty_q      <= dirty_d;
    end
  end

  assign i2c_ack_o    = i2c_ack_q;
  assign i2c_rdata_o  = i2c_rdata_q;
  assign host_ack_o   = host_ack_q;
  assign host_rdata_o = host_rdata_q;
  assign dirty_o      = dirty_q;
  assign busy_o       = state_q != ST_IDLE;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_we_o     = mem_we_q;
endmodule

// File: tb/tb_cmos_access_arbiter.sv
// tb_cmos_access_arbiter: scoreboard bench with a behavioural store and arbitration model
module tb_cmos_access_arbiter;
  import cmos_arb_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic i2c_req_i = 0, i2c_we_i = 0, host_req_i = 0, host_we_i = 0, host_dirty_clr_i = 0;
  logic [7:0] i2c_addr_i = 0, i2c_wdata_i = 0, host_addr_i = 0, host_wdata_i = 0;
  logic i2c_ack_o, host_ack_o, dirty_o, busy_o, mem_we_o;
  logic [7:0] i2c_rdata_o, host_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;

  typedef struct {bit port; bit chk; logic [7:0] rdata; bit dirty;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0, wc = 0;
  logic [7:0] store [256];
  logic [7:0] ref_mem [256];
  bit m_last, m_dirty;

  cmos_access_arbiter dut (
    .clk(clk), .rst(rst),
    .i2c_req_i(i2c_req_i), .i2c_we_i(i2c_we_i), .i2c_addr_i(i2c_addr_i), .i2c_wdata_i(i2c_wdata_i),
    .i2c_ack_o(i2c_ack_o), .i2c_rdata_o(i2c_rdata_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_wdata_i(host_wdata_i),
    .host_ack_o(host_ack_o), .host_rdata_o(host_rdata_o),
    .host_dirty_clr_i(host_dirty_clr_i), .dirty_o(dirty_o), .busy_o(busy_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_we_o(mem_we_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we_o) store[mem_addr_o] <= mem_wdata_o;
    mem_rdata_i <= store[mem_addr_o];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) wc = 0;
    else begin
      if (mem_we_o) wc++;
      else if (wc != 0) begin
        chk("mem_we_width", wc, 1);
        wc = 0;
      end
      if (i2c_ack_o || host_ack_o) begin
        chk("single_ack", {31'd0, i2c_ack_o & host_ack_o}, 0);
        if (sb.size() == 0) chk("unexpected_ack", sb.size(), 1);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("ack_port", {31'd0, host_ack_o}, {31'd0, e.port});
          if (e.chk) chk(e.port ? "host_rdata" : "i2c_rdata", e.port ? host_rdata_o : i2c_rdata_o, e.rdata);
          chk("ack_dirty", {31'd0, dirty_o}, {31'd0, e.dirty});
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    i2c_req_i = 0; host_req_i = 0; host_dirty_clr_i = 0;
    m_last = GNT_HOST; m_dirty = 0; sb.delete();
    @(negedge clk);
    chk("rst_busy", busy_o, 0); chk("rst_dirty", dirty_o, 0); chk("rst_mem_we", mem_we_o, 0);
    chk("rst_acks", {i2c_ack_o, host_ack_o}, 0); chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_wdata", mem_wdata_o, 0); chk("rst_rdatas", {i2c_rdata_o, host_rdata_o}, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Predict grant order and results from the round-robin rule, then drive and watch the acks.
  task automatic run(input bit ie, input bit iw, input logic [7:0] ia, input logic [7:0] id,
                     input bit he, input bit hw, input logic [7:0] ha, input logic [7:0] hd,
                     input bit clr = 0);
    bit first, got_i, got_h;
    int n = 0, n_i = 0, n_h = 0;
    first = (ie && he) ? ~m_last : he;
    if (clr) m_dirty = 0;
    for (int k = 0; k < 2; k++) begin
      bit p, w;
      logic [7:0] a, d;
      exp_t e;
      p = (k == 0) ? first : ~first;
      if (p ? he : ie) begin
        w = p ? hw : iw; a = p ? ha : ia; d = p ? hd : id;
        e.port = p; e.chk = !w; e.rdata = ref_mem[a];
        if (w) ref_mem[a] = d;
        if (!p && w && a >= 8'h10) m_dirty = 1;
        e.dirty = m_dirty;
        m_last = p;
        sb.push_back(e);
      end
    end
    @(posedge clk); #1;
    i2c_req_i = ie; i2c_we_i = iw; i2c_addr_i = ia; i2c_wdata_i = id;
    host_req_i = he; host_we_i = hw; host_addr_i = ha; host_wdata_i = hd;
    got_i = !ie; got_h = !he;
    while (!(got_i && got_h) && n < 30) begin
      @(negedge clk);
      n++;
      if (clr) host_dirty_clr_i = (n == 3);
      if (i2c_ack_o && !got_i) begin got_i = 1; n_i = n; i2c_req_i = 0; end
      if (host_ack_o && !got_h) begin got_h = 1; n_h = n; host_req_i = 0; end
    end
    i2c_req_i = 0; host_req_i = 0; host_dirty_clr_i = 0;
    chk("ack_timeout", {31'd0, got_i && got_h}, 1);
    if (ie) chk("i2c_latency", n_i, (he && first == GNT_HOST) ? 8 : 4);
    if (he) chk("host_latency", n_h, (ie && first == GNT_I2C) ? 8 : 4);
    chk("dirty", {31'd0, dirty_o}, {31'd0, m_dirty});
  endtask

  task automatic clear_dirty();
    @(posedge clk); #1 host_dirty_clr_i = 1;
    @(posedge clk); #1 host_dirty_clr_i = 0;
    m_dirty = 0;
    chk("dirty_clr", {31'd0, dirty_o}, 0);
  endtask

  task automatic held_read(input logic [7:0] a);
    int n = 0, na = 0, nb = 0;
    exp_t e;
    e.port = GNT_I2C; e.chk = 1; e.rdata = ref_mem[a]; e.dirty = m_dirty;
    sb.push_back(e); sb.push_back(e);
    m_last = GNT_I2C;
    @(posedge clk); #1;
    i2c_req_i = 1; i2c_we_i = 0; i2c_addr_i = a;
    while (nb == 0 && n < 30) begin
      @(negedge clk);
      n++;
      if (i2c_ack_o) begin
        if (na == 0) na = n; else nb = n;
      end
    end
    i2c_req_i = 0;
    chk("held_first_ack", na, 4);
    chk("held_second_ack", nb, 8);
  endtask

  task automatic reset_mid();
    @(posedge clk); #1;
    host_req_i = 1; host_we_i = 1; host_addr_i = 8'h50; host_wdata_i = 8'h77;
    @(posedge clk); #2;
    chk("issue_mem_we", {31'd0, mem_we_o}, 1);
    chk("issue_busy", {31'd0, busy_o}, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_mem_we", {31'd0, mem_we_o}, 0);
    chk("rst_mid_busy", {31'd0, busy_o}, 0);
    chk("rst_mid_ack", {i2c_ack_o, host_ack_o}, 0);
    host_req_i = 0; m_last = GNT_HOST; m_dirty = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      store[i] = 8'($urandom);
      ref_mem[i] = store[i];
    end
    store[3] = 8'h33; ref_mem[3] = 8'h33;
    do_reset();
    run(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00);
    run(0, 0, 8'h00, 8'h00, 1, 1, 8'h40, 8'hA5);
    run(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00);
    do_reset();
    run(1, 0, 8'h08, 8'h00, 1, 0, 8'h09, 8'h00);
    run(1, 0, 8'h0A, 8'h00, 0, 0, 8'h00, 8'h00);
    run(1, 1, 8'h30, 8'h5A, 1, 0, 8'h30, 8'h00);
    run(1, 1, 8'h05, 8'h12, 0, 0, 8'h00, 8'h00);
    run(1, 1, 8'h0F, 8'h34, 0, 0, 8'h00, 8'h00);
    run(1, 1, 8'h10, 8'h01, 0, 0, 8'h00, 8'h00);
    clear_dirty();
    run(1, 1, 8'h20, 8'h02, 0, 0, 8'h00, 8'h00, 1);
    clear_dirty();
    run(0, 0, 8'h00, 8'h00, 1, 1, 8'h60, 8'hC3);
    held_read(8'h07);
    reset_mid();
    run(1, 0, 8'h50, 8'h00, 0, 0, 8'h00, 8'h00);
    repeat (80) begin
      logic [1:0] pick;
      pick = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) clear_dirty();
      run(pick[0], 1'($urandom), rnd_addr(), 8'($urandom),
          pick[1], 1'($urandom), rnd_addr(), 8'($urandom));
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
